iob_ptfloat_pack_arb: RTL and testbench

Round-robin arbiter that shares one iob_ptfloat_pack instance between N_REQ result producers, such as the adder, multiplier, divider and sqrt units.
- Accepts {exp, man} packing requests over valid/ready.
- Issues at most one request per cycle into the non-stallable pack pipeline.
- Tracks requester IDs through the pipeline latency.
- Buffers packed results in a credit-protected FIFO, returned over a single tagged valid/ready response channel.

---
 rtl/iob_ptfloat_pack_arb.sv | 156 +++++++++++++++
 tb/tb_iob_ptfloat_pack_arb.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_ptfloat_pack_arb.sv
// iob_ptfloat_pack_arb: shares one ptfloat pack unit among N_REQ producers; define PTFLOAT_PACK_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin
module iob_ptfloat_pack_arb #(
    parameter int DATA_W     = 32,
    parameter int EW_W       = 4,
    parameter int N_REQ      = 4,
    parameter int ID_W       = 2,
    parameter int PACK_LAT   = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int EXP_MAX_W  = 2 ** (EW_W - 1),
    parameter int RES_MAX_W  = DATA_W
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           cke_i,
    input  logic [N_REQ-1:0]               req_valid_i,
    output logic [N_REQ-1:0]               req_ready_o,
    input  logic [N_REQ*(EXP_MAX_W+2)-1:0] req_exp_i,
    input  logic [N_REQ*RES_MAX_W-1:0]     req_man_i,
    output logic                           pack_start_o,
    output logic [EXP_MAX_W+1:0]           pack_exp_o,
    output logic [RES_MAX_W-1:0]           pack_man_o,
    input  logic                           pack_done_i,
    input  logic [DATA_W-1:0]              pack_data_i,
    input  logic                           pack_overflow_i,
    input  logic                           pack_underflow_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [ID_W-1:0]                rsp_id_o,
    output logic [DATA_W-1:0]              rsp_data_o,
    output logic                           rsp_overflow_o,
    output logic                           rsp_underflow_o,
    output logic                           err_o
);
    localparam int EXP_W = EXP_MAX_W + 2;
    localparam int ENT_W = ID_W + DATA_W + 2;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = $clog2(FIFO_DEPTH + PACK_LAT + 1);
    localparam int BLK_W = $clog2(PACK_LAT + 1);

    logic [ID_W-1:0]               winner;
    logic                          any_valid, grant_ok, transfer, push, pop, full, blank;
    logic [SUM_W-1:0]              inflight;
    logic [PACK_LAT-1:0]           tag_v_q;
    logic [PACK_LAT-1:0][ID_W-1:0] tag_id_q;
    logic [ENT_W-1:0]              mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]              wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [BLK_W-1:0]              blank_q;
    logic                          err_q, err_d;

`ifdef PTFLOAT_PACK_ARB_FIXED_PRIO_EN
    // Fixed priority: the lowest valid index wins
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                winner    = ID_W'(i);
                any_valid = 1'b1;
            end
        end
    end
`else
    logic [ID_W-1:0] ptr_q, idx;
    // Round-robin: first valid requester after the previous winner
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = ID_W'((int'(ptr_q) + i) % N_REQ);
            if (req_valid_i[idx]) begin
                winner    = idx;
                any_valid = 1'b1;
            end
        end
    end

    // Pointer moves to the winner only on an accepted request
    always_ff @(posedge clk_i) begin
        if (rst_i) ptr_q <= ID_W'(N_REQ - 1);
        else if (transfer) ptr_q <= winner;
    end
`endif

    // Results already promised: tags still inside the pack pipeline
    always_comb begin
        inflight = '0;
        for (int i = 0; i < PACK_LAT; i++) inflight = inflight + SUM_W'(tag_v_q[i]);
    end

    // Winner's operands go to the pack unit even when nothing is issued
    always_comb begin
        pack_exp_o = req_exp_i[EXP_W-1:0];
        pack_man_o = req_man_i[RES_MAX_W-1:0];
        for (int k = 0; k < N_REQ; k++) begin
            if (winner == ID_W'(k)) begin
                pack_exp_o = req_exp_i[k*EXP_W +: EXP_W];
                pack_man_o = req_man_i[k*RES_MAX_W +: RES_MAX_W];
            end
        end
    end

    // A same-cycle pop is not credited, so an issued result always finds room
    assign grant_ok     = cke_i & ~rst_i & ((inflight + SUM_W'(cnt_q)) < SUM_W'(FIFO_DEPTH));
    assign transfer     = grant_ok & any_valid;
    assign req_ready_o  = N_REQ'(transfer) << winner;
    assign pack_start_o = transfer;

    assign push        = tag_v_q[PACK_LAT-1];
    assign full        = cnt_q == CNT_W'(FIFO_DEPTH);
    assign rsp_valid_o = cnt_q != '0;
    assign pop         = cke_i & rsp_valid_o & rsp_ready_i;
    assign cnt_d       = cnt_q + CNT_W'(push & ~full) - CNT_W'(pop);
    assign blank       = blank_q != '0;
    assign err_d       = err_q | (~blank & (pack_done_i ^ push)) | (push & full);
    assign err_o       = err_q;
    assign {rsp_id_o, rsp_data_o, rsp_overflow_o, rsp_underflow_o} = mem_q[rd_ptr_q];

    // Tag pipeline carries each issued requester ID through the pack latency
    always_ff @(posedge clk_i) begin
        if (rst_i) tag_v_q <= '0;
        else if (cke_i) begin
            for (int i = PACK_LAT - 1; i > 0; i--) begin
                tag_v_q[i]  <= tag_v_q[i-1];
                tag_id_q[i] <= tag_id_q[i-1];
            end
            tag_v_q[0]  <= transfer;
            tag_id_q[0] <= winner;
        end
    end

    // FIFO storage is written from the last tag stage, not from pack_done_i
    always_ff @(posedge clk_i) begin
        if (cke_i && push && !full)
            mem_q[wr_ptr_q] <= {tag_id_q[PACK_LAT-1], pack_data_i, pack_overflow_i, pack_underflow_i};
    end

    // FIFO pointers, occupancy, post-reset error blanking and sticky error
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            blank_q  <= BLK_W'(PACK_LAT);
        end else if (cke_i) begin
            if (push && !full) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (blank) blank_q <= blank_q - BLK_W'(1);
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
endmodule

// File: tb/tb_iob_ptfloat_pack_arb.sv
// tb_iob_ptfloat_pack_arb: scoreboard bench for the shared pack-unit arbiter with a behavioural 2-cycle pack unit
module tb_iob_ptfloat_pack_arb;
    localparam int N  = 4;
    localparam int EW = 10;
    localparam int MW = 32;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
        logic        ov;
        logic        un;
    } rsp_t;

    logic          clk = 1'b0, rst = 1'b1, cke = 1'b1, rsp_ready = 1'b0, force_done = 1'b0;
    logic [N-1:0]  valid = '0;
    logic [EW-1:0] exp_v [N];
    logic [MW-1:0] man_v [N];
    logic [N*EW-1:0] req_exp;
    logic [N*MW-1:0] req_man;
    logic [N-1:0]  req_ready_o;
    logic          pack_start_o, pack_done_i, pack_overflow_i, pack_underflow_i;
    logic [EW-1:0] pack_exp_o;
    logic [MW-1:0] pack_man_o, pack_data_i;
    logic          rsp_valid_o, rsp_overflow_o, rsp_underflow_o, err_o;
    logic [1:0]    rsp_id_o;
    logic [31:0]   rsp_data_o;
    logic [1:0]    pm_v = '0;
    logic [EW-1:0] pm_e [2];
    logic [MW-1:0] pm_m [2];
    rsp_t          sb[$];
    int            glog[$];
    int            checks = 0, failures = 0, cyc = 0, m_ptr = N - 1;
    bit            vary = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_flat
        assign req_exp[g*EW +: EW] = exp_v[g];
        assign req_man[g*MW +: MW] = man_v[g];
    end

    iob_ptfloat_pack_arb dut (
        .clk_i(clk), .rst_i(rst), .cke_i(cke),
        .req_valid_i(valid), .req_ready_o(req_ready_o),
        .req_exp_i(req_exp), .req_man_i(req_man),
        .pack_start_o(pack_start_o), .pack_exp_o(pack_exp_o), .pack_man_o(pack_man_o),
        .pack_done_i(pack_done_i), .pack_data_i(pack_data_i),
        .pack_overflow_i(pack_overflow_i), .pack_underflow_i(pack_underflow_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id_o),
        .rsp_data_o(rsp_data_o), .rsp_overflow_o(rsp_overflow_o),
        .rsp_underflow_o(rsp_underflow_o), .err_o(err_o)
    );

    // Stand-in pack unit: data = man + exp, overflow = exp[9], underflow = exp[8]
    always @(posedge clk) begin
        if (cke) begin
            pm_v    <= {pm_v[0], pack_start_o};
            pm_e[0] <= pack_exp_o;
            pm_e[1] <= pm_e[0];
            pm_m[0] <= pack_man_o;
            pm_m[1] <= pm_m[0];
        end
    end
    assign pack_done_i      = pm_v[1] | force_done;
    assign pack_data_i      = pm_m[1] + 32'(pm_e[1]);
    assign pack_overflow_i  = pm_e[1][9];
    assign pack_underflow_i = pm_e[1][8];

    function automatic rsp_t pack_f(int id, logic [EW-1:0] e, logic [MW-1:0] m);
        rsp_t r;
        r.id   = 2'(id);
        r.data = m + 32'(e);
        r.ov   = e[9];
        r.un   = e[8];
        return r;
    endfunction

    task automatic check(string nm, logic [63:0] act, logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", nm, act, want);
        end
    endtask

    task automatic fill();
        for (int k = 0; k < N; k++) begin
            exp_v[k] = 10'((cyc & 1) << 9 | k << 7 | cyc % 128);
            man_v[k] = 32'(k << 28 | cyc * 3);
        end
    endtask

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            if (vary) fill();
        end
    endtask

    task automatic drain();
        int n;
        n         = 0;
        valid     = '0;
        rsp_ready = 1'b1;
        while (sb.size() != 0 && n < 40) begin
            step();
            n++;
        end
        check("drain_timeout", 64'(sb.size()), 64'(0));
        step(3);
    endtask

    // Issue side: reference arbiter predicts the grant and pushes the expected response
    initial forever begin
        @(negedge clk);
        begin : issue
            int w;
            bit any;
            logic [N-1:0] er;
            any = 1'b0;
            w   = 0;
            for (int i = 1; i <= N; i++) begin
                if (!any && valid[(m_ptr + i) % N]) begin
                    w   = (m_ptr + i) % N;
                    any = 1'b1;
                end
            end
            er = (any && cke && !rst && sb.size() < 4) ? 4'b0001 << w : 4'b0000;
            check("req_ready", 64'(req_ready_o), 64'(er));
            check("pack_start", 64'(pack_start_o), 64'(|er));
            if (er != 0) begin
                check("pack_exp", 64'(pack_exp_o), 64'(exp_v[w]));
                check("pack_man", 64'(pack_man_o), 64'(man_v[w]));
                sb.push_back(pack_f(w, exp_v[w], man_v[w]));
                glog.push_back(w);
                m_ptr = w;
            end
            if (rst) m_ptr = N - 1;
        end
    end

    // Monitor: pops the scoreboard on every response handshake
    initial forever begin
        @(negedge clk);
        #2;
        begin : mon
            rsp_t e;
            if (sb.size() == 0) check("rsp_spurious", 64'(rsp_valid_o), 64'(0));
            else if (cke && rsp_valid_o && rsp_ready) begin
                e = sb.pop_front();
                check("rsp_id", 64'(rsp_id_o), 64'(e.id));
                check("rsp_data", 64'(rsp_data_o), 64'(e.data));
                check("rsp_ovf", 64'(rsp_overflow_o), 64'(e.ov));
                check("rsp_unf", 64'(rsp_underflow_o), 64'(e.un));
            end
            if (rst) sb.delete();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            exp_v[k] = '0;
            man_v[k] = '0;
        end
        step(2);
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
        check("rst_err", 64'(err_o), 64'(0));
        check("rst_ready", 64'(req_ready_o), 64'(0));
        step();
        rst = 1'b0;
        step(3);

        // Round-robin with all requesters valid: 0,1,2,3,... one per cycle
        glog.delete();
        vary      = 1'b1;
        fill();
        rsp_ready = 1'b1;
        valid     = '1;
        step(12);
        drain();
        check("rr_count", 64'(glog.size()), 64'(12));
        for (int i = 0; i < glog.size(); i++) check($sformatf("rr_grant[%0d]", i), 64'(glog[i]), 64'(i % 4));

        // Single request from requester 2, response three cycles later
        vary     = 1'b0;
        exp_v[2] = 10'h005;
        man_v[2] = 32'h4000_0000;
        valid    = 4'b0100;
        @(negedge clk);
        check("single_start", 64'(pack_start_o), 64'(1));
        check("single_ready", 64'(req_ready_o), 64'(4'b0100));
        step();
        valid = '0;
        @(negedge clk);
        check("single_lat1", 64'(rsp_valid_o), 64'(0));
        step();
        @(negedge clk);
        check("single_lat2", 64'(rsp_valid_o), 64'(0));
        step();
        @(negedge clk);
        check("single_valid", 64'(rsp_valid_o), 64'(1));
        check("single_id", 64'(rsp_id_o), 64'(2));
        check("single_data", 64'(rsp_data_o), 64'(32'h4000_0005));
        check("single_err", 64'(err_o), 64'(0));
        drain();

        // Backpressure: exactly four issues, then stall until the consumer drains
        glog.delete();
        vary      = 1'b1;
        fill();
        rsp_ready = 1'b0;
        valid     = '1;
        step(10);
        @(negedge clk);
        check("bp_stall_ready", 64'(req_ready_o), 64'(0));
        check("bp_count", 64'(glog.size()), 64'(4));
        step();
        rsp_ready = 1'b1;
        step(12);
        drain();
        check("bp_resume", 64'(glog.size() >= 8), 64'(1));
        for (int i = 0; i < glog.size(); i++) check($sformatf("bp_grant[%0d]", i), 64'(glog[i]), 64'((3 + i) % 4));

        // Reset one cycle after two issues: no stale response, no error, requester 0 first
        valid = '1;
        step(2);
        valid = '0;
        rst   = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("mid_rst_valid", 64'(rsp_valid_o), 64'(0));
            check("mid_rst_err", 64'(err_o), 64'(0));
            step();
        end
        valid = '1;
        @(negedge clk);
        check("mid_rst_first", 64'(req_ready_o), 64'(4'b0001));
        step();
        drain();

        // Clock enable low freezes everything; head of the FIFO holds
        valid = '1;
        step(5);
        cke = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("cke_ready", 64'(req_ready_o), 64'(0));
            check("cke_hold_valid", 64'(rsp_valid_o), 64'(1));
            check("cke_hold_id", 64'(rsp_id_o), 64'(sb[0].id));
            check("cke_hold_data", 64'(rsp_data_o), 64'(sb[0].data));
            step();
        end
        cke = 1'b1;
        drain();

        // Spurious pack_done_i sets a sticky error without a FIFO write
        vary       = 1'b0;
        force_done = 1'b1;
        @(negedge clk);
        check("perr_before", 64'(err_o), 64'(0));
        step();
        force_done = 1'b0;
        @(negedge clk);
        check("perr_set", 64'(err_o), 64'(1));
        check("perr_nowrite", 64'(rsp_valid_o), 64'(0));
        step(3);
        @(negedge clk);
        check("perr_sticky", 64'(err_o), 64'(1));
        check("perr_nowrite2", 64'(rsp_valid_o), 64'(0));
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("perr_cleared", 64'(err_o), 64'(0));
        step(3);

        @(negedge clk);
        check("end_idle", 64'(rsp_valid_o), 64'(0));
        check("end_sb_empty", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
